// File: rtl/nibble_history.sv
// nibble_history: four-deep history of nibbles written from an i4001 I/O port,
// with a saturating 16-bit write counter and a freezable 4-digit display.
module nibble_history (
   input  logic       i_clk,
   input  logic       i_in_clr,
   input  logic [3:0] i_data_in,
   input  logic       i_wr,
   input  logic       i_mode,
   input  logic       i_freeze,
   output logic [3:0] o_d1,
   output logic [3:0] o_d2,
   output logic [3:0] o_d3,
   output logic [3:0] o_d4,
   output logic       o_new,
   output logic       o_ovf
);

   localparam int unsigned NIB_W = 4;
   localparam int unsigned CNT_W = 16;
   localparam int unsigned DSP_W = 4 * NIB_W;
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   logic             r_wr_q;
   logic [NIB_W-1:0] r_h1, r_h2, r_h3, r_h4;
   logic [CNT_W-1:0] r_cnt;
   logic [DSP_W-1:0] r_disp;
   logic             r_new;
   logic             r_ovf;

   logic             w_accept;
   logic             w_cnt_sat;
   logic [DSP_W-1:0] w_disp_src;

   // A write is the rising edge of the strobe; long strobes count once.
   assign w_accept  = i_wr & ~r_wr_q;
   assign w_cnt_sat = (r_cnt == CNT_MAX);

   // Select display source from pre-edge history or counter.
   always_comb begin
      w_disp_src = {r_h4, r_h3, r_h2, r_h1};
      if (i_mode) begin
         w_disp_src = DSP_W'(r_cnt);
      end
   end

   // Strobe delay; resets high so a strobe held through reset is ignored.
   always_ff @(posedge i_clk) begin
      if (!i_in_clr) begin
         r_wr_q <= 1'b1;
      end else begin
         r_wr_q <= i_wr;
      end
   end

   // History shift register, newest nibble in H1.
   always_ff @(posedge i_clk) begin
      if (!i_in_clr) begin
         r_h1 <= '0;
         r_h2 <= '0;
         r_h3 <= '0;
         r_h4 <= '0;
      end else if (w_accept) begin
         r_h4 <= r_h3;
         r_h3 <= r_h2;
         r_h2 <= r_h1;
         r_h1 <= i_data_in;
      end
   end

   // Saturating write counter with sticky overflow flag.
   always_ff @(posedge i_clk) begin
      if (!i_in_clr) begin
         r_cnt <= '0;
         r_ovf <= 1'b0;
      end else if (w_accept) begin
         if (w_cnt_sat) begin
            r_ovf <= 1'b1;
         end else begin
            r_cnt <= r_cnt + CNT_W'(1);
         end
      end
   end

   // Display registers; hold while frozen.
   always_ff @(posedge i_clk) begin
      if (!i_in_clr) begin
         r_disp <= '0;
      end else if (!i_freeze) begin
         r_disp <= w_disp_src;
      end
   end

   // One-cycle pulse per accepted write.
   always_ff @(posedge i_clk) begin
      if (!i_in_clr) begin
         r_new <= 1'b0;
      end else begin
         r_new <= w_accept;
      end
   end

   assign o_d1  = r_disp[3:0];
   assign o_d2  = r_disp[7:4];
   assign o_d3  = r_disp[11:8];
   assign o_d4  = r_disp[15:12];
   assign o_new = r_new;
   assign o_ovf = r_ovf;

endmodule
